fp_round32_l2: RTL and testbench

Rounding and packing stage for single-precision results: consumes the normalized sign/exponent/significand-plus-guard/sticky word produced by the 32-bit normalization unit and emits an IEEE 754 binary32 word with exception flags. It sits at the tail of the add/mul/div datapaths, directly after normalization. It is a two-stage pipeline with valid/ready flow control.

---
 rtl/fp_round32_l2.sv | 153 +++++++++++++++
 tb/tb_fp_round32_l2.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fp_round32_l2.sv
// rtl/fp_round32_l2.sv - binary32 round-and-pack stage, two-stage valid/ready pipe
// Optional: FP_ROUND_FTZ_EN flushes denormal results to signed zero.
module fp_round32_l2 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_valid,
  output logic        i_ready,
  input  logic        i_sign,
  input  logic [7:0]  i_exp,
  input  logic [25:0] i_sig,
  input  logic        i_inexact,
  input  logic [2:0]  i_rm,
  output logic        o_valid,
  input  logic        o_ready,
  output logic [31:0] o_data,
  output logic        o_overflow,
  output logic        o_underflow,
  output logic        o_inexact
);

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  logic        advance;
  logic        v1_q, v2_q;
  logic        sign1_q, sign1_d;
  logic [7:0]  exp1_q, exp1_d;
  logic [24:0] sum1_q, sum1_d;
  logic        inexact1_q, inexact1_d;
  logic [2:0]  rm1_q, rm1_d;
  logic        special1_q, special1_d;
  logic        zero1_q, zero1_d;
  logic        inc;

  logic [31:0] data_q, data_d;
  logic        ovf_q, ovf_d;
  logic        unf_q, unf_d;
  logic        inx_q, inx_d;

  assign advance = !v2_q || o_ready;
  assign i_ready = advance;
  assign o_valid = v2_q;
  assign o_data = data_q;
  assign o_overflow = ovf_q;
  assign o_underflow = unf_q;
  assign o_inexact = inx_q;

  // Stage 1: rounding increment decision and significand add.
  always_comb begin
    rm1_d = (i_rm > RM_RMM) ? RM_RNE : i_rm;
    special1_d = (i_exp == 8'hFF);
    zero1_d = (i_exp == 8'h00) && (i_sig == 26'd0);
    inc = 1'b0;
    case (rm1_d)
      RM_RNE: inc = i_sig[1] & (i_sig[0] | i_sig[2]);
      RM_RTZ: inc = 1'b0;
      RM_RDN: inc = i_sign & (i_sig[1] | i_sig[0]);
      RM_RUP: inc = !i_sign & (i_sig[1] | i_sig[0]);
      RM_RMM: inc = i_sig[1];
      default: inc = 1'b0;
    endcase
    if (special1_d) inc = 1'b0;
    sum1_d = {1'b0, i_sig[25:2]} + {24'd0, inc};
    sign1_d = i_sign;
    exp1_d = i_exp;
    inexact1_d = i_sig[1] | i_sig[0] | i_inexact;
  end

  logic [8:0]  exp_adj;
  logic [22:0] frac_adj;
  logic [22:0] frac_nan;

  // Stage 2: exponent adjust, overflow saturation, specials and pack.
  always_comb begin
    exp_adj = {1'b0, exp1_q};
    frac_adj = sum1_q[22:0];
    if (sum1_q[24]) begin
      exp_adj = {1'b0, exp1_q} + 9'd1;
      frac_adj = sum1_q[23:1];
    end else if (exp1_q == 8'h00 && sum1_q[23]) begin
      exp_adj = 9'd1;
    end
    frac_nan = sum1_q[22:0] | 23'h400000;

    data_d = 32'd0;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    inx_d = 1'b0;
    if (!v1_q) begin
      data_d = 32'd0;
    end else if (special1_q) begin
      data_d = {sign1_q, 8'hFF, (sum1_q[22:0] == 23'd0) ? 23'd0 : frac_nan};
    end else if (zero1_q) begin
      data_d = {sign1_q, 31'd0};
    end else if (exp_adj >= 9'h0FF) begin
      ovf_d = 1'b1;
      inx_d = 1'b1;
      case (rm1_q)
        RM_RTZ: data_d = {sign1_q, 31'h7F7FFFFF};
        RM_RDN: data_d = sign1_q ? 32'hFF800000 : 32'h7F7FFFFF;
        RM_RUP: data_d = sign1_q ? 32'hFF7FFFFF : 32'h7F800000;
        default: data_d = {sign1_q, 31'h7F800000};
      endcase
    end else begin
      data_d = {sign1_q, exp_adj[7:0], frac_adj};
      inx_d = inexact1_q;
      unf_d = (exp_adj[7:0] == 8'h00) && inexact1_q;
`ifdef FP_ROUND_FTZ_EN
      if (exp_adj[7:0] == 8'h00 && frac_adj != 23'd0) begin
        data_d = {sign1_q, 31'd0};
        unf_d = 1'b1;
        inx_d = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      sign1_q <= 1'b0;
      exp1_q <= 8'd0;
      sum1_q <= 25'd0;
      inexact1_q <= 1'b0;
      rm1_q <= RM_RNE;
      special1_q <= 1'b0;
      zero1_q <= 1'b0;
      data_q <= 32'd0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      inx_q <= 1'b0;
    end else if (advance) begin
      v1_q <= i_valid;
      v2_q <= v1_q;
      sign1_q <= sign1_d;
      exp1_q <= exp1_d;
      sum1_q <= sum1_d;
      inexact1_q <= inexact1_d;
      rm1_q <= rm1_d;
      special1_q <= special1_d;
      zero1_q <= zero1_d;
      data_q <= data_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      inx_q <= inx_d;
    end
  end

endmodule

// File: tb/tb_fp_round32_l2.sv
// tb/tb_fp_round32_l2.sv - directed bench for fp_round32_l2 with expected-word queue
module tb_fp_round32_l2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid;
  logic        i_ready;
  logic        i_sign;
  logic [7:0]  i_exp;
  logic [25:0] i_sig;
  logic        i_inexact;
  logic [2:0]  i_rm;
  logic        o_valid;
  logic        o_ready;
  logic [31:0] o_data;
  logic        o_overflow;
  logic        o_underflow;
  logic        o_inexact;

  always #5 clk = ~clk;

  fp_round32_l2 dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(i_ready),
    .i_sign(i_sign), .i_exp(i_exp), .i_sig(i_sig), .i_inexact(i_inexact), .i_rm(i_rm),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data),
    .o_overflow(o_overflow), .o_underflow(o_underflow), .o_inexact(o_inexact)
  );

`ifdef FP_ROUND_FTZ_EN
  localparam bit FTZ = 1'b1;
`else
  localparam bit FTZ = 1'b0;
`endif

  typedef struct packed {
    logic        ck_ovf;
    logic [31:0] data;
    logic        ovf;
    logic        unf;
    logic        inx;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int n_checks = 0;
  int n_pass = 0;
  int n_out = 0;
  int n_sent = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expv);
  endtask

  task automatic send(input logic s, input logic [7:0] e, input logic [25:0] sig,
                      input logic inx, input logic [2:0] rm, input logic [31:0] xd,
                      input logic ck_ovf, input logic xo, input logic xu, input logic xi);
    int cnt;
    i_valid = 1'b1;
    i_sign = s;
    i_exp = e;
    i_sig = sig;
    i_inexact = inx;
    i_rm = rm;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!i_ready && cnt < 100);
    if (!i_ready) check("send_timeout", 32'(i_ready), 32'd1);
    else begin
      exp_q.push_back('{ck_ovf, xd, xo, xu, xi});
      n_sent++;
    end
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && o_valid && o_ready) begin
      if (exp_q.size() == 0) check("unexpected_out", 32'd1, 32'd0);
      else begin
        mon_e = exp_q.pop_front();
        check($sformatf("data[%0d]", n_out), o_data, mon_e.data);
        if (mon_e.ck_ovf) check($sformatf("ovf[%0d]", n_out), 32'(o_overflow), 32'(mon_e.ovf));
        check($sformatf("unf[%0d]", n_out), 32'(o_underflow), 32'(mon_e.unf));
        check($sformatf("inx[%0d]", n_out), 32'(o_inexact), 32'(mon_e.inx));
        n_out++;
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    o_ready = 1'b1;
    i_valid = 1'b0;
    i_sign = 1'b0;
    i_exp = 8'd0;
    i_sig = 26'd0;
    i_inexact = 1'b0;
    i_rm = 3'd0;
    repeat (2) @(negedge clk);
    check("rst_o_valid", 32'(o_valid), 32'd0);
    check("rst_o_data", o_data, 32'd0);
    check("rst_flags", {29'd0, o_overflow, o_underflow, o_inexact}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_i_ready", 32'(i_ready), 32'd1);
    @(posedge clk);
    #1;

    // Latency: presented after edge N, o_valid low after N+1, high after N+2.
    send(0, 8'h7F, 26'h2000000, 0, 3'd0, 32'h3F800000, 1, 0, 0, 0);
    @(negedge clk);
    check("lat_n1", 32'(o_valid), 32'd0);
    @(negedge clk);
    check("lat_n2", 32'(o_valid), 32'd1);
    @(posedge clk);
    #1;

    send(0, 8'h7F, 26'h2000002, 0, 3'd0, 32'h3F800000, 1, 0, 0, 1);
    send(0, 8'h7F, 26'h2000006, 0, 3'd0, 32'h3F800002, 1, 0, 0, 1);
    send(0, 8'h7F, 26'h2000002, 0, 3'd4, 32'h3F800001, 1, 0, 0, 1);
    send(0, 8'h7F, 26'h2000006, 0, 3'd4, 32'h3F800002, 1, 0, 0, 1);
    send(0, 8'h7F, 26'h3FFFFFE, 0, 3'd0, 32'h40000000, 1, 0, 0, 1);
    send(0, 8'h7F, 26'h3FFFFFE, 0, 3'd1, 32'h3FFFFFFF, 1, 0, 0, 1);
    send(0, 8'hFE, 26'h3FFFFFF, 0, 3'd0, 32'h7F800000, 1, 1, 0, 1);
    send(0, 8'hFE, 26'h3FFFFFF, 0, 3'd1, 32'h7F7FFFFF, 0, 0, 0, 1);
    send(1, 8'hFE, 26'h3FFFFFF, 0, 3'd3, 32'hFF7FFFFF, 0, 0, 0, 1);
    send(1, 8'hFE, 26'h3FFFFFF, 0, 3'd2, 32'hFF800000, 1, 1, 0, 1);
    send(0, 8'hFE, 26'h3FFFFFF, 0, 3'd3, 32'h7F800000, 1, 1, 0, 1);
    send(0, 8'h00, 26'h0000006, 0, 3'd0, FTZ ? 32'h0 : 32'h2, 1, 0, 1, 1);
    send(0, 8'h00, 26'h0000008, 0, 3'd0, FTZ ? 32'h0 : 32'h2, 1, 0, FTZ, FTZ);
    send(0, 8'h00, 26'h1FFFFFE, 0, 3'd0, 32'h00800000, 1, 0, 0, 1);
    send(0, 8'hFF, 26'h0000004, 0, 3'd0, 32'h7FC00001, 1, 0, 0, 0);
    send(1, 8'hFF, 26'h2000000, 1, 3'd0, 32'hFF800000, 1, 0, 0, 0);
    send(1, 8'h00, 26'h0000000, 1, 3'd0, 32'h80000000, 1, 0, 0, 0);
    send(0, 8'h7F, 26'h2000002, 0, 3'd7, 32'h3F800000, 1, 0, 0, 1);
    send(0, 8'h7F, 26'h2000006, 0, 3'd5, 32'h3F800002, 1, 0, 0, 1);
    send(0, 8'h7F, 26'h2000002, 0, 3'd2, 32'h3F800000, 1, 0, 0, 1);
    send(0, 8'h7F, 26'h2000002, 0, 3'd3, 32'h3F800001, 1, 0, 0, 1);
    send(0, 8'h7F, 26'h2000000, 1, 3'd1, 32'h3F800000, 1, 0, 0, 1);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;

    fork
      begin
        for (int k = 0; k < 5; k++)
          send(0, 8'h7F + 8'(k), 26'h2000000 + 26'(k << 2), 0, 3'd0,
               ((32'h7F + 32'(k)) << 23) | 32'(k), 1, 0, 0, 0);
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        o_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("stall_o_valid", 32'(o_valid), 32'd1);
          check("stall_i_ready", 32'(i_ready), 32'd0);
          check("stall_data", o_data, 32'h3F800000);
        end
        @(posedge clk);
        #1;
        o_ready = 1'b1;
      end
    join
    repeat (6) @(negedge clk);
    check("delivered", 32'(n_out), 32'(n_sent));
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset while a word is held on the output.
    @(posedge clk);
    #1;
    o_ready = 1'b0;
    send(1, 8'hFE, 26'h3FFFFFF, 0, 3'd0, 32'hFF800000, 1, 1, 0, 1);
    begin
      int k;
      k = 0;
      while (!o_valid && k < 20) begin
        @(negedge clk);
        k++;
      end
    end
    check("pre_rst_valid", 32'(o_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_o_valid", 32'(o_valid), 32'd0);
    check("mid_rst_o_data", o_data, 32'd0);
    check("mid_rst_flags", {29'd0, o_overflow, o_underflow, o_inexact}, 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    o_ready = 1'b1;
    @(negedge clk);
    check("post_rst_i_ready", 32'(i_ready), 32'd1);
    repeat (3) @(negedge clk);
    check("post_rst_o_valid", 32'(o_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
